// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// Holds the FSM state enum, parity modes and frame-length helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Line cycles per frame: start + 8 data + optional parity + stops.
    function automatic int frame_len(
        input int parity,
        input int stop_bits
    );
        return 10 + ((parity != PAR_NONE) ? 1 : 0) + (stop_bits - 1);
    endfunction

    function automatic logic parity_bit(
        input logic [7:0] d,
        input int         parity
    );
        return (parity == PAR_ODD) ? ~^d : ^d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO in front of the UART shifter.
// Ports: clk, reset, push/din, pop/dout (show-ahead), level, full, empty.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    localparam int AW = LW - 1;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Extra pointer MSB tells full from empty when low bits match.
    assign dout  = mem[rd_ptr[AW-1:0]];
    assign level = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_tx_serializer.sv
// Buffered UART transmitter: one bit per baud_clk, LSB first.
// Ports: baud_clk, reset, uart_enable/data_in in; tx, busy, overflow, fifo_level out.
module uart_tx_serializer #(
    parameter  int FIFO_DEPTH = 4,
    parameter  int PARITY     = 0,
    parameter  int STOP_BITS  = 1,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          baud_clk,
    input  logic          reset,
    input  logic          uart_enable,
    input  logic [7:0]    data_in,
    output logic          tx,
    output logic          busy,
    output logic          overflow,
    output logic [LW-1:0] fifo_level
);

    import uart_pkg::*;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic       stop_cnt;
    logic       par_bit;

    logic       push;
    logic       pop;
    logic       drop;
    logic       full;
    logic       empty;
    logic       stop_last;
    logic [7:0] fifo_dout;
    logic [LW-1:0] level_nxt;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk   (baud_clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (data_in),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    assign stop_last = (state == ST_STOP) &&
                       (stop_cnt == 1'(STOP_BITS - 1));

    // Pop from IDLE, or on the last stop bit for a gapless next frame.
    assign pop  = !empty && ((state == ST_IDLE) || stop_last);
    // A pop in the same cycle frees a slot for a write while full.
    assign push = uart_enable && (!full || pop);
    assign drop = uart_enable && full && !pop;

    assign level_nxt = fifo_level
                     + {{(LW-1){1'b0}}, push}
                     - {{(LW-1){1'b0}}, pop};

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (pop) state_nxt = ST_START;
            end
            ST_START: state_nxt = ST_DATA;
            ST_DATA: begin
                if (bit_cnt == 3'd7) begin
                    state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: state_nxt = ST_STOP;
            ST_STOP: begin
                if (stop_last) state_nxt = pop ? ST_START : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge baud_clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            overflow <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != ST_IDLE) || (level_nxt != '0);

            if (drop) begin
                overflow <= 1'b1;
            end

            // Parity is latched from the whole byte before it is shifted.
            if (pop) begin
                shreg   <= fifo_dout;
                par_bit <= parity_bit(fifo_dout, PARITY);
            end

            unique case (state)
                ST_IDLE: tx <= ~pop;
                ST_START: begin
                    tx      <= shreg[0];
                    shreg   <= shreg >> 1;
                    bit_cnt <= '0;
                end
                ST_DATA: begin
                    if (bit_cnt == 3'd7) begin
                        tx       <= (PARITY != PAR_NONE) ? par_bit : 1'b1;
                        stop_cnt <= 1'b0;
                    end else begin
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                ST_PARITY: begin
                    tx       <= 1'b1;
                    stop_cnt <= 1'b0;
                end
                ST_STOP: begin
                    if (stop_last) begin
                        tx <= ~pop;
                    end else begin
                        tx       <= 1'b1;
                        stop_cnt <= stop_cnt + 1'b1;
                    end
                end
                default: tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer.
// Scoreboard of queued bytes checked against frames decoded from tx.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en_a = 1'b0;
    logic       en_b = 1'b0;
    logic [7:0] din = 8'h00;

    logic       tx_a, busy_a, ovf_a;
    logic       tx_b, busy_b, ovf_b;
    logic [2:0] lvl_a, lvl_b;

    always #5 clk = ~clk;

    uart_tx_serializer u_a (
        .baud_clk    (clk),
        .reset       (reset),
        .uart_enable (en_a),
        .data_in     (din),
        .tx          (tx_a),
        .busy        (busy_a),
        .overflow    (ovf_a),
        .fifo_level  (lvl_a)
    );

    uart_tx_serializer #(
        .FIFO_DEPTH (4),
        .PARITY     (2),
        .STOP_BITS  (2)
    ) u_b (
        .baud_clk    (clk),
        .reset       (reset),
        .uart_enable (en_b),
        .data_in     (din),
        .tx          (tx_b),
        .busy        (busy_b),
        .overflow    (ovf_b),
        .fifo_level  (lvl_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic       sel_b = 1'b0;
    logic       mon_en = 1'b0;
    logic       mon_tx;
    logic [7:0] exp_q [$];
    int         fstart [$];
    int         frames = 0;
    int         cyc = 0;
    int         maxlvl = 0;
    int         mbit = -1;
    logic [7:0] mbyte;
    logic       mpar;
    logic [7:0] e;

    assign mon_tx = sel_b ? tx_b : tx_a;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mon_en && !sel_b && int'(lvl_a) > maxlvl) maxlvl = int'(lvl_a);
    end

    // Frame decoder: start, 8 data, [parity], stop bit(s).
    always @(negedge clk) begin
        if (!mon_en) begin
            mbit = -1;
        end else if (mbit < 0) begin
            if (mon_tx === 1'b0) begin
                mbit = 0;
                fstart.push_back(cyc);
            end
        end else begin
            if (mbit < 8) mbyte[mbit] = mon_tx;
            else if (sel_b && mbit == 8) mpar = mon_tx;
            else chk("stop_bit", 32'(mon_tx), 1);
            mbit++;
            if (mbit == (sel_b ? 11 : 9)) begin
                mbit = -1;
                frames++;
                chk("frame_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("frame_data", 32'(mbyte), 32'(e));
                    if (sel_b) chk("frame_parity", 32'(mpar), 32'(~^e));
                end
            end
        end
    end

    // Called at a negedge: strobe is sampled at the next posedge.
    task automatic strobe(input logic [7:0] d, input bit push_exp);
        din = d;
        if (sel_b) en_b = 1'b1;
        else en_a = 1'b1;
        if (push_exp) exp_q.push_back(d);
        @(negedge clk);
        en_a = 1'b0;
        en_b = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        mon_en = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        frames = 0;
        maxlvl = 0;
        exp_q.delete();
        fstart.delete();
        mon_en = 1'b1;
    endtask

    task automatic wait_frames(input int n, input int budget);
        for (int i = 0; i < budget && frames < n; i++) @(negedge clk);
        chk("frames_done", 32'(frames), 32'(n));
    endtask

    logic [9:0] fr;
    int         lows;

    initial begin
        do_reset();
        chk("rst_tx", 32'(tx_a), 1);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_ovf", 32'(ovf_a), 0);
        chk("rst_lvl", 32'(lvl_a), 0);
        chk("rst_tx_b", 32'(tx_b), 1);

        // Single byte, explicit line trace.
        strobe(8'hA5, 1'b1);
        chk("t1_lvl", 32'(lvl_a), 1);
        chk("t1_busy", 32'(busy_a), 1);
        fr = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("t1_bit%0d", k), 32'(tx_a), 32'(fr[k]));
        end
        @(negedge clk);
        chk("t1_busy_end", 32'(busy_a), 0);
        chk("t1_lvl_end", 32'(lvl_a), 0);
        wait_frames(1, 20);

        // Upstream cadence of 11 cycles.
        do_reset();
        strobe(8'h55, 1'b1);
        repeat (10) @(negedge clk);
        strobe(8'h0D, 1'b1);
        repeat (10) @(negedge clk);
        strobe(8'h0A, 1'b1);
        wait_frames(3, 60);
        chk("t2_ovf", 32'(ovf_a), 0);
        chk("t2_maxlvl", 32'(maxlvl <= 1), 1);
        for (int i = 1; i < fstart.size(); i++)
            chk("t2_spacing", 32'(fstart[i] - fstart[i-1]), 11);

        // Burst into a busy transmitter: 4 fit, 5th dropped.
        do_reset();
        strobe(8'h11, 1'b1);
        repeat (2) @(negedge clk);
        strobe(8'h21, 1'b1);
        strobe(8'h32, 1'b1);
        strobe(8'h43, 1'b1);
        strobe(8'h54, 1'b1);
        chk("t3_full", 32'(lvl_a), 4);
        strobe(8'h65, 1'b0);
        chk("t3_ovf", 32'(ovf_a), 1);
        chk("t3_lvl", 32'(lvl_a), 4);
        wait_frames(5, 100);
        for (int i = 1; i < fstart.size(); i++)
            chk("t3_gap", 32'(fstart[i] - fstart[i-1]), 10);
        repeat (2) @(negedge clk);
        chk("t3_ovf_sticky", 32'(ovf_a), 1);
        chk("t3_busy_end", 32'(busy_a), 0);

        // Write while full on the STOP->START pop edge.
        do_reset();
        strobe(8'hA1, 1'b1);
        repeat (2) @(negedge clk);
        strobe(8'hB2, 1'b1);
        strobe(8'hC3, 1'b1);
        strobe(8'hD4, 1'b1);
        strobe(8'hE5, 1'b1);
        chk("t4_full", 32'(lvl_a), 4);
        repeat (4) @(negedge clk);
        strobe(8'hF6, 1'b1);
        chk("t4_ovf", 32'(ovf_a), 0);
        chk("t4_lvl", 32'(lvl_a), 4);
        wait_frames(6, 120);
        chk("t4_ovf_end", 32'(ovf_a), 0);

        // Odd parity, two stop bits.
        sel_b = 1'b1;
        do_reset();
        strobe(8'h07, 1'b1);
        strobe(8'h80, 1'b1);
        wait_frames(2, 60);
        for (int i = 1; i < fstart.size(); i++)
            chk("t5_len", 32'(fstart[i] - fstart[i-1]), 12);
        repeat (2) @(negedge clk);
        chk("t5_busy_end", 32'(busy_b), 0);
        chk("t5_ovf", 32'(ovf_b), 0);

        // Reset mid-frame with two bytes queued.
        sel_b = 1'b0;
        do_reset();
        mon_en = 1'b0;
        strobe(8'h3C, 1'b0);
        strobe(8'h01, 1'b0);
        strobe(8'h02, 1'b0);
        chk("t6_queued", 32'(lvl_a), 2);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_tx", 32'(tx_a), 1);
        chk("t6_busy", 32'(busy_a), 0);
        chk("t6_lvl", 32'(lvl_a), 0);
        reset = 1'b0;
        lows = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx_a !== 1'b1) lows++;
        end
        chk("t6_no_frames", 32'(lows), 0);
        chk("t6_busy_end", 32'(busy_a), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
